// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared stall vector codes, sequencer states and default widths
package pipe_stall_ctrl_pkg;

  localparam int CNT_W_DEF   = 6;
  localparam int STALL_W_DEF = 6;

  // bit k stalls register k: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// rtl/pipe_stall_ctrl_mc_seq.sv - multi-cycle EX sequencer: down-counter FSM producing the EX stall request
module pipe_stall_ctrl_mc_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_start_i,
  input  logic [CNT_W-1:0] ex_cycles_i,
  input  logic             mem_stallreq_i,
  input  logic             flush_i,
  output logic             mc_stallreq,
  output logic             ex_busy_o,
  output logic             ex_done_o
);

  mc_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             mc_start;

  // The start cycle already stalls, so the counter is loaded with N-1.
  assign mc_start    = (state == MC_IDLE) && ex_start_i && (ex_cycles_i != '0) && !flush_i;
  assign mc_stallreq = mc_start || (state == MC_BUSY);
  assign ex_busy_o   = busy_q;
  assign ex_done_o   = done_q && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MC_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (flush_i) begin
      state  <= MC_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (mc_start) begin
            cnt <= ex_cycles_i - 1'b1;
            if (ex_cycles_i == CNT_W'(1)) begin
              state  <= MC_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= MC_BUSY;
              busy_q <= 1'b1;
            end
          end
        end
        // Keeps counting under a MEM stall: the EX unit is still computing.
        MC_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= MC_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        MC_DONE: begin
          if (!mem_stallreq_i) begin
            state  <= MC_IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= MC_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller: priority stall merge, multi-cycle EX sequencing
// Optional stall performance counter enabled by STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stallreq_i,
  input  logic               id_stallreq_i,
  input  logic               ex_start_i,
  input  logic [CNT_W-1:0]   ex_cycles_i,
  input  logic               mem_stallreq_i,
  input  logic               flush_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               ex_busy_o,
  output logic               ex_done_o,
  output logic [31:0]        stall_cycles_o
);

  logic               mc_stallreq;
  logic [STALL_W-1:0] stall_merged;

  pipe_stall_ctrl_mc_seq #(
    .CNT_W (CNT_W)
  ) u_mc_seq (
    .clk            (clk),
    .rst            (rst),
    .ex_start_i     (ex_start_i),
    .ex_cycles_i    (ex_cycles_i),
    .mem_stallreq_i (mem_stallreq_i),
    .flush_i        (flush_i),
    .mc_stallreq    (mc_stallreq),
    .ex_busy_o      (ex_busy_o),
    .ex_done_o      (ex_done_o)
  );

  // Deepest requesting stage wins; flush cancels every stall.
  always_comb begin
    stall_merged = STALL_NONE;
    if (flush_i)             stall_merged = STALL_NONE;
    else if (mem_stallreq_i) stall_merged = STALL_MEM;
    else if (mc_stallreq)    stall_merged = STALL_EX;
    else if (id_stallreq_i)  stall_merged = STALL_ID;
    else if (if_stallreq_i)  stall_merged = STALL_IF;
  end

  assign stall_o = rst ? stall_merged : STALL_NONE;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_o[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl (scoreboard of per-cycle expectations)
module tb_pipe_stall_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IF   = 6'b000011;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

`ifdef STALL_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd10;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  // stim = {if, id, mem, flush, ex_start}; bd = {busy, done}
  typedef struct {
    logic [4:0] stim;
    logic [5:0] n;
    logic [5:0] es;
    logic [1:0] bd;
  } row_t;

  logic        clk;
  logic        rst;
  logic        if_stallreq_i;
  logic        id_stallreq_i;
  logic        ex_start_i;
  logic [5:0]  ex_cycles_i;
  logic        mem_stallreq_i;
  logic        flush_i;
  logic [5:0]  stall_o;
  logic        ex_busy_o;
  logic        ex_done_o;
  logic [31:0] stall_cycles_o;

  logic [7:0]  exp_q[$];
  int          n_pass;
  int          n_total;

  pipe_stall_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_stallreq_i  (if_stallreq_i),
    .id_stallreq_i  (id_stallreq_i),
    .ex_start_i     (ex_start_i),
    .ex_cycles_i    (ex_cycles_i),
    .mem_stallreq_i (mem_stallreq_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .ex_busy_o      (ex_busy_o),
    .ex_done_o      (ex_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input row_t r);
    {if_stallreq_i, id_stallreq_i, mem_stallreq_i, flush_i, ex_start_i} = r.stim;
    ex_cycles_i = r.n;
    exp_q.push_back({r.es, r.bd});
  endtask

  task automatic test_reset();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rst = 1'b0;
    {if_stallreq_i, id_stallreq_i, mem_stallreq_i, flush_i, ex_start_i} = 5'b11001;
    ex_cycles_i = 6'd10;
    #2;
    n_total++;
    if ({stall_o, ex_busy_o, ex_done_o} !== 8'h00)
      $display("FAIL reset_hold: got %b expected %b", {stall_o, ex_busy_o, ex_done_o}, 8'h00);
    else n_pass++;
    n_total++;
    if (stall_cycles_o !== 32'd0)
      $display("FAIL reset_perf: got %0d expected 0", stall_cycles_o);
    else n_pass++;
    {if_stallreq_i, id_stallreq_i, mem_stallreq_i, flush_i, ex_start_i} = 5'b00000;
    #10 rst = 1'b1;
    @(posedge clk); #1;
    rows.push_back('{5'b00001, 6'd10, S_EX, 2'b00});
    for (int i = 0; i < 4; i++) rows.push_back('{5'b00001, 6'd10, S_EX, 2'b10});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reset_pre cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
    // BUSY with cnt=5: assert reset between edges
    rst = 1'b0;
    #1;
    n_total++;
    if ({stall_o, ex_busy_o, ex_done_o} !== 8'h00)
      $display("FAIL reset_async: got %b expected %b", {stall_o, ex_busy_o, ex_done_o}, 8'h00);
    else n_pass++;
    @(posedge clk); #1;
    ex_start_i = 1'b0;
    #2 rst = 1'b1;
    rows.delete();
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    rows.push_back('{5'b00001, 6'd1, S_EX,   2'b00});
    rows.push_back('{5'b00001, 6'd1, S_NONE, 2'b01});
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reset_post cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rows.push_back('{5'b01100, 6'd0, S_MEM,  2'b00});
    rows.push_back('{5'b01000, 6'd0, S_ID,   2'b00});
    rows.push_back('{5'b10000, 6'd0, S_IF,   2'b00});
    rows.push_back('{5'b11000, 6'd0, S_ID,   2'b00});
    rows.push_back('{5'b00100, 6'd0, S_MEM,  2'b00});
    rows.push_back('{5'b11110, 6'd0, S_NONE, 2'b00});
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL priority row %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rows.push_back('{5'b00001, 6'd32, S_EX, 2'b00});
    for (int i = 1; i < 32; i++) rows.push_back('{5'b00001, 6'd32, S_EX, 2'b10});
    rows.push_back('{5'b00001, 6'd32, S_NONE, 2'b01});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    rows.push_back('{5'b00001, 6'd1,  S_EX,   2'b00});
    rows.push_back('{5'b00001, 6'd1,  S_NONE, 2'b01});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    for (int i = 0; i < 3; i++) rows.push_back('{5'b00001, 6'd0, S_NONE, 2'b00});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    // ID and EX together: EX wins, ID shows once the EX stall is released
    rows.push_back('{5'b01001, 6'd3,  S_EX,   2'b00});
    rows.push_back('{5'b01001, 6'd3,  S_EX,   2'b10});
    rows.push_back('{5'b01001, 6'd3,  S_EX,   2'b10});
    rows.push_back('{5'b01001, 6'd3,  S_ID,   2'b01});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL div cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_overlap();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rows.push_back('{5'b00001, 6'd4, S_EX,   2'b00});
    rows.push_back('{5'b00001, 6'd4, S_EX,   2'b10});
    rows.push_back('{5'b00101, 6'd4, S_MEM,  2'b10});
    rows.push_back('{5'b00101, 6'd4, S_MEM,  2'b10});
    rows.push_back('{5'b00101, 6'd4, S_MEM,  2'b01});
    rows.push_back('{5'b00001, 6'd4, S_NONE, 2'b01});
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL mem_overlap cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rows.push_back('{5'b00001, 6'd20, S_EX, 2'b00});
    for (int i = 0; i < 9; i++) rows.push_back('{5'b00001, 6'd20, S_EX, 2'b10});
    rows.push_back('{5'b00011, 6'd20, S_NONE, 2'b10});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    rows.push_back('{5'b00001, 6'd1,  S_EX,   2'b00});
    rows.push_back('{5'b00011, 6'd1,  S_NONE, 2'b00});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    rows.push_back('{5'b00011, 6'd5,  S_NONE, 2'b00});
    rows.push_back('{5'b00000, 6'd0,  S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL flush cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
    row_t       rows[$];
    logic [7:0] got;
    logic [7:0] want;
    rst = 1'b0;
    #2 rst = 1'b1;
    n_total++;
    if (stall_cycles_o !== 32'd0) $display("FAIL perf_clear: got %0d expected 0", stall_cycles_o);
    else n_pass++;
    @(posedge clk); #1;
    rows.push_back('{5'b00001, 6'd8, S_EX, 2'b00});
    for (int i = 0; i < 7; i++) rows.push_back('{5'b00001, 6'd8, S_EX, 2'b10});
    rows.push_back('{5'b00001, 6'd8, S_NONE, 2'b01});
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    rows.push_back('{5'b01000, 6'd0, S_ID,   2'b00});
    rows.push_back('{5'b01000, 6'd0, S_ID,   2'b00});
    rows.push_back('{5'b00000, 6'd0, S_NONE, 2'b00});
    foreach (rows[k]) begin
      apply(rows[k]);
      @(negedge clk);
      got = {stall_o, ex_busy_o, ex_done_o};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL perf cycle %0d: got %b expected %b", k, got, want);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++;
    if (stall_cycles_o !== PERF_EXP)
      $display("FAIL perf_count: got %0d expected %0d", stall_cycles_o, PERF_EXP);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_priority();
    test_div();
    test_mem_overlap();
    test_flush();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
